// File: rtl/note_pkg.sv
// Shared types, note-code limits and the half-period helper for the
// note-code to square-wave tone generator.
package note_pkg;

  typedef enum logic [1:0] {
    REST,
    PLAY,
    GAP
  } state_t;

  localparam logic [4:0] NOTE_REST = 5'd0;
  localparam logic [4:0] NOTE_MAX  = 5'd21;

  // C4 D4 E4 F4 G4 A4 B4 in Hz; codes 8..21 are the same notes one and two octaves up.
  localparam int BASE_HZ [7] = '{262, 294, 330, 349, 392, 440, 494};

  // Half-period in clock cycles for a code; 0 for codes that do not sound.
  function automatic int half_period(input int clk_hz, input int code);
    int f;
    f = 0;
    if (code >= 1 && code <= int'(NOTE_MAX)) begin
      f = BASE_HZ[(code - 1) % 7] << ((code - 1) / 7);
    end
    half_period = (f == 0) ? 0 : (clk_hz + f) / (2 * f);
  endfunction

endpackage

// File: rtl/note_divisor_rom.sv
// Constant lookup from note code to half-period in clock cycles; the table
// is folded at elaboration, so this is pure combinational logic.
module note_divisor_rom
  import note_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DIV_W  = 18
) (
  input  logic [4:0]       code,
  output logic [DIV_W-1:0] half
);

  logic [DIV_W-1:0] rom [32];

  for (genvar i = 0; i < 32; i++) begin : g_entry
    localparam logic [DIV_W-1:0] HALF = DIV_W'(half_period(CLK_HZ, i));
    assign rom[i] = HALF;
  end

  assign half = rom[code];

endmodule

// File: rtl/note_tone_gen.sv
// Note-code to speaker square wave: registers the code, looks up its
// half-period and toggles spk, with an optional silent gap on note changes.
module note_tone_gen
  import note_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int GAP_CYCLES = 0,
  parameter int DIV_W      = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ifplay,
  input  logic [4:0] note_code,
  output logic       spk,
  output logic [4:0] cur_note,
  output logic       tone_on
);

  localparam bit               USE_GAP  = (GAP_CYCLES > 0);
  localparam logic [DIV_W-1:0] GAP_LAST = DIV_W'(USE_GAP ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [4:0]       code_q;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half_q;
  logic [DIV_W-1:0] rom_half;
  logic             sounding;

  note_divisor_rom #(
    .CLK_HZ(CLK_HZ),
    .DIV_W (DIV_W)
  ) u_rom (
    .code(code_q),
    .half(rom_half)
  );

  assign sounding = ifplay && (code_q != NOTE_REST) && (code_q <= NOTE_MAX);

  // NOTE: every register here is updated with <= so all branches see the
  // pre-edge values of state, cnt and cur_note, exactly as flops do.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REST;
      code_q   <= NOTE_REST;
      cnt      <= '0;
      half_q   <= '0;
      spk      <= 1'b0;
      cur_note <= NOTE_REST;
      tone_on  <= 1'b0;
    end else begin
      code_q <= note_code;
      case (state)
        REST: begin
          spk <= 1'b0;
          cnt <= '0;
          if (sounding) begin
            state    <= PLAY;
            spk      <= 1'b1;
            cur_note <= code_q;
            half_q   <= rom_half;
            tone_on  <= 1'b1;
          end
        end

        PLAY: begin
          if (!sounding) begin
            state    <= REST;
            spk      <= 1'b0;
            cnt      <= '0;
            cur_note <= NOTE_REST;
            tone_on  <= 1'b0;
          end else if (code_q != cur_note) begin
            cnt <= '0;
            if (USE_GAP) begin
              state    <= GAP;
              spk      <= 1'b0;
              cur_note <= NOTE_REST;
              tone_on  <= 1'b0;
            end else begin
              spk      <= 1'b1;
              cur_note <= code_q;
              half_q   <= rom_half;
            end
          end else if (cnt == half_q - DIV_W'(1)) begin
            spk <= ~spk;
            cnt <= '0;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

        GAP: begin
          // The pending code is code_q itself, so the ROM output already
          // matches whatever code is current when the gap ends.
          if (!sounding) begin
            state    <= REST;
            spk      <= 1'b0;
            cnt      <= '0;
            cur_note <= NOTE_REST;
            tone_on  <= 1'b0;
          end else if (cnt == GAP_LAST) begin
            state    <= PLAY;
            spk      <= 1'b1;
            cnt      <= '0;
            cur_note <= code_q;
            half_q   <= rom_half;
            tone_on  <= 1'b1;
          end else begin
            cnt <= cnt + DIV_W'(1);
          end
        end

        default: begin
          state    <= REST;
          spk      <= 1'b0;
          cnt      <= '0;
          cur_note <= NOTE_REST;
          tone_on  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_tone_gen.sv
// Bench for note_tone_gen: two instances (gap 4 and gap 0) share one directed
// stimulus stream and are compared every cycle against a timing-based model.
module tb_note_tone_gen;

  localparam int CLK_HZ = 1_000_000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       ifplay = 1'b0;
  logic [4:0] note_code = 5'd0;

  logic       spk_g, spk_n, tone_g, tone_n;
  logic [4:0] cur_g, cur_n;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  note_tone_gen #(.CLK_HZ(CLK_HZ), .GAP_CYCLES(4), .DIV_W(18)) dut_gap (
    .clk(clk), .rst_n(rst_n), .ifplay(ifplay), .note_code(note_code),
    .spk(spk_g), .cur_note(cur_g), .tone_on(tone_g)
  );

  note_tone_gen #(.CLK_HZ(CLK_HZ), .GAP_CYCLES(0), .DIV_W(18)) dut_nogap (
    .clk(clk), .rst_n(rst_n), .ifplay(ifplay), .note_code(note_code),
    .spk(spk_n), .cur_note(cur_n), .tone_on(tone_n)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each tone is described by its start cycle and half-period; spk follows
  // from elapsed time, a gap by its start cycle and length.
  localparam int BASE[7] = '{262, 294, 330, 349, 392, 440, 494};
  localparam int GAPS[2] = '{4, 0};

  typedef enum {M_OFF, M_TONE, M_GAP} mmode_t;

  mmode_t     mode[2]    = '{M_OFF, M_OFF};
  int         mnote[2]   = '{0, 0};
  int         mhalf[2]   = '{1, 1};
  longint     mstart[2]  = '{0, 0};
  longint     mgstart[2] = '{0, 0};
  logic [4:0] mcq = 5'd0;
  longint     cyc = 0;

  function automatic int tone_half(input logic [4:0] c);
    int ci, f;
    ci = int'(c);
    f  = BASE[(ci - 1) % 7] * (1 << ((ci - 1) / 7));
    return (CLK_HZ + f) / (2 * f);
  endfunction

  function automatic bit audible(input logic play, input logic [4:0] c);
    return play && (c >= 5'd1) && (c <= 5'd21);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcq <= 5'd0;
      for (int m = 0; m < 2; m++) begin
        mode[m]  <= M_OFF;
        mnote[m] <= 0;
      end
    end else begin
      cyc <= cyc + 1;
      mcq <= note_code;
      for (int m = 0; m < 2; m++) begin
        case (mode[m])
          M_OFF: if (audible(ifplay, mcq)) begin
            mode[m]   <= M_TONE;
            mnote[m]  <= int'(mcq);
            mstart[m] <= cyc + 1;
            mhalf[m]  <= tone_half(mcq);
          end
          M_TONE: if (!audible(ifplay, mcq)) begin
            mode[m]  <= M_OFF;
            mnote[m] <= 0;
          end else if (int'(mcq) != mnote[m]) begin
            if (GAPS[m] > 0) begin
              mode[m]    <= M_GAP;
              mnote[m]   <= 0;
              mgstart[m] <= cyc + 1;
            end else begin
              mnote[m]  <= int'(mcq);
              mstart[m] <= cyc + 1;
              mhalf[m]  <= tone_half(mcq);
            end
          end
          M_GAP: if (!audible(ifplay, mcq)) begin
            mode[m] <= M_OFF;
          end else if (cyc - mgstart[m] == longint'(GAPS[m] - 1)) begin
            mode[m]   <= M_TONE;
            mnote[m]  <= int'(mcq);
            mstart[m] <= cyc + 1;
            mhalf[m]  <= tone_half(mcq);
          end
          default: mode[m] <= M_OFF;
        endcase
      end
    end
  end

  function automatic logic exp_spk(input int m);
    return (mode[m] == M_TONE) && (((cyc - mstart[m]) / mhalf[m]) % 2 == 0);
  endfunction

  function automatic int exp_cur(input int m);
    return (mode[m] == M_TONE) ? mnote[m] : 0;
  endfunction

  always @(negedge clk) begin
    check("model_spk_gap",    spk_g,  exp_spk(0));
    check("model_cur_gap",    cur_g,  exp_cur(0));
    check("model_on_gap",     tone_g, mode[0] == M_TONE);
    check("model_spk_nogap",  spk_n,  exp_spk(1));
    check("model_cur_nogap",  cur_n,  exp_cur(1));
    check("model_on_nogap",   tone_n, mode[1] == M_TONE);
  end

  // ---------------- directed stimulus ----------------
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Counts consecutive cycles (including the current one) with spk at level.
  task automatic measure(input int which, input logic level, output int len);
    len = 0;
    while (((which == 0) ? spk_g : spk_n) === level && len < 4000) begin
      len++;
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    int len, a, b, c;
    #1 rst_n = 1'b0;
    cycles(3);
    rst_n = 1'b1;
    check("reset_spk", spk_g, 0);
    check("reset_cur", cur_g, 0);
    check("reset_on",  tone_g, 0);
    cycles(2);

    // Steady tone on code 6 (A4): half = 1136.
    ifplay    = 1'b1;
    note_code = 5'd6;
    cycles(1);
    check("t1_spk_after_capture", spk_g, 0);
    cycles(1);
    check("t1_spk_start", spk_g, 1);
    check("t1_cur", cur_g, 6);
    check("t1_on", tone_g, 1);
    measure(0, 1'b1, len);
    check("t1_high_len", len, 1136);
    measure(0, 1'b0, len);
    check("t1_low_len", len, 1136);

    // Change 6 -> 8 (C5, half 954): gap of 4 vs immediate restart.
    note_code = 5'd8;
    cycles(1);
    check("t2_cur_before", cur_g, 6);
    check("t3_spk_before", spk_n, 1);
    cycles(1);
    check("t2_gap_spk", spk_g, 0);
    check("t2_gap_cur", cur_g, 0);
    check("t2_gap_on",  tone_g, 0);
    check("t3_spk_restart", spk_n, 1);
    check("t3_cur", cur_n, 8);
    fork
      begin
        measure(0, 1'b0, a);
        measure(0, 1'b1, b);
      end
      begin
        measure(1, 1'b1, c);
      end
    join
    check("t2_gap_len", a, 4);
    check("t2_high_len", b, 954);
    check("t3_high_len", c, 954);
    check("t2_cur_after", cur_g, 8);

    // Rest via code 0 and via code 25.
    note_code = 5'd0;
    cycles(1);
    check("t4_on_before", tone_g, 1);
    cycles(1);
    check("t4_rest0_spk", spk_g, 0);
    check("t4_rest0_on",  tone_g, 0);
    check("t4_rest0_cur", cur_g, 0);
    note_code = 5'd6;
    cycles(2);
    check("t4_replay_cur", cur_g, 6);
    note_code = 5'd25;
    cycles(2);
    check("t4_rest25_spk", spk_g, 0);
    check("t4_rest25_on",  tone_n, 0);
    check("t4_rest25_cur", cur_g, 0);

    // ifplay dropped for 10 cycles on code 21 (B6, half 253).
    note_code = 5'd21;
    cycles(2);
    check("t5_cur", cur_g, 21);
    cycles(100);
    ifplay = 1'b0;
    cycles(1);
    check("t5_off_spk", spk_g, 0);
    check("t5_off_on",  tone_g, 0);
    check("t5_off_cur", cur_g, 0);
    cycles(9);
    ifplay = 1'b1;
    cycles(1);
    check("t5_resume_spk", spk_g, 1);
    check("t5_resume_cur", cur_g, 21);
    measure(0, 1'b1, len);
    check("t5_high_len", len, 253);

    // Asynchronous reset mid-tone on code 6.
    note_code = 5'd6;
    cycles(50);
    check("t6_on_before", tone_g, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_async_spk_gap",   spk_g, 0);
    check("t6_async_cur_gap",   cur_g, 0);
    check("t6_async_on_gap",    tone_g, 0);
    check("t6_async_spk_nogap", spk_n, 0);
    check("t6_async_on_nogap",  tone_n, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cycles(1);
    check("t6_spk_after_release", spk_g, 0);
    cycles(1);
    check("t6_spk_start", spk_g, 1);
    measure(0, 1'b1, len);
    check("t6_high_len", len, 1136);

    cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
